// File: rtl/adder_pkg.sv
// Shared geometry helpers for the pipelined adder: chunk width, chunk base
// index and the legality check on the WIDTH/STAGES pair.
package adder_pkg;

  // Bits resolved by each pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Index of the least significant bit of chunk k.
  function automatic int stage_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  // The operand must split evenly and every stage must own at least one bit.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice used by every pipeline stage; the
// multi-bit successor to the half/full adder cells.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign {co, s} = total;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder/subtractor split into STAGES chunks, one chunk resolved per
// stage, with the carry rippling through pipeline registers. Each stage keeps
// only the operand bits still to be added, so register width shrinks down the
// pipe. Valid/ready per stage lets empty stages fill under a downstream stall.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_geometry_check
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Subtraction is a + ~b + 1, so invert b and force the carry-in up front.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = stage_lo(k, CHUNK);
    localparam int SW = LO + CHUNK;     // sum bits resolved so far
    localparam int RW = WIDTH - SW;     // operand bits still pending

    logic             valid_r;
    logic             carry_r;
    logic [SW-1:0]    sum_r;
    logic             ready_s;
    logic             src_valid_s;
    logic             ci_s;
    logic [CHUNK-1:0] ca_s;
    logic [CHUNK-1:0] cb_s;
    logic [CHUNK-1:0] s_s;
    logic             co_s;
    logic [SW-1:0]    next_sum_s;

    if (k == 0) begin : g_src
      assign src_valid_s = in_valid;
      assign ci_s        = cin_eff;
      assign ca_s        = a[CHUNK-1:0];
      assign cb_s        = b_eff[CHUNK-1:0];
      assign next_sum_s  = s_s;
    end else begin : g_src
      assign src_valid_s = g_stage[k-1].valid_r;
      assign ci_s        = g_stage[k-1].carry_r;
      assign ca_s        = g_stage[k-1].g_ops.a_r[CHUNK-1:0];
      assign cb_s        = g_stage[k-1].g_ops.b_r[CHUNK-1:0];
      assign next_sum_s  = {s_s, g_stage[k-1].sum_r};
    end

    // A stage can load when it is empty or its contents move on this edge.
    if (k == STAGES - 1) begin : g_ready
      assign ready_s = !valid_r || out_ready;
    end else begin : g_ready
      assign ready_s = !valid_r || g_stage[k+1].ready_s;
    end

    adder_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a  (ca_s),
      .b  (cb_s),
      .ci (ci_s),
      .s  (s_s),
      .co (co_s)
    );

    // Stage valid, carry and partial sum advance together when the stage is ready.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= {SW{1'b0}};
      end else if (ready_s) begin
        valid_r <= src_valid_s;
        carry_r <= co_s;
        sum_r   <= next_sum_s;
      end
    end

    if (RW > 0) begin : g_ops
      logic [RW-1:0] a_r;
      logic [RW-1:0] b_r;
      logic [RW-1:0] src_a_s;
      logic [RW-1:0] src_b_s;

      if (k == 0) begin : g_ops_src
        assign src_a_s = a[WIDTH-1:SW];
        assign src_b_s = b_eff[WIDTH-1:SW];
      end else begin : g_ops_src
        assign src_a_s = g_stage[k-1].g_ops.a_r[RW+CHUNK-1:CHUNK];
        assign src_b_s = g_stage[k-1].g_ops.b_r[RW+CHUNK-1:CHUNK];
      end

      // Carry the not-yet-added operand chunks alongside the partial sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= {RW{1'b0}};
          b_r <= {RW{1'b0}};
        end else if (ready_s) begin
          a_r <= src_a_s;
          b_r <= src_b_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_msb
      logic a_msb_r;
      logic b_msb_r;

      // Keep the operand sign bits of the final chunk for the overflow flag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_msb_r <= 1'b0;
          b_msb_r <= 1'b0;
        end else if (ready_s) begin
          a_msb_r <= ca_s[CHUNK-1];
          b_msb_r <= cb_s[CHUNK-1];
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ready_s;
  assign out_valid = g_stage[STAGES-1].valid_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].carry_r;
  assign ovf       = (g_stage[STAGES-1].g_msb.a_msb_r == g_stage[STAGES-1].g_msb.b_msb_r) &&
                     (g_stage[STAGES-1].sum_r[WIDTH-1] != g_stage[STAGES-1].g_msb.a_msb_r);

endmodule
